// File: rtl/alu_modul_if.sv
// Operand/result bundle for the execute-stage ALU.
// The master drives the operands and the function code. The slave returns the registered result and flags.
interface alu_modul_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       Funct;
  logic [4:0]       Shamt;
  logic [WIDTH-1:0] Rs;
  logic [WIDTH-1:0] Rt;
  logic [WIDTH-1:0] Result;
  logic             carryOut;
  logic             Zero;
  logic             overFlow;

  modport master (
    output Funct, Shamt, Rs, Rt,
    input  Result, carryOut, Zero, overFlow
  );

  modport slave (
    input  Funct, Shamt, Rs, Rt,
    output Result, carryOut, Zero, overFlow
  );
endinterface

// File: rtl/alu_modul.sv
// Registered MIPS-style R-type ALU. It has one cycle of latency and accepts a new operation every cycle.
// The result, carry, zero and overflow outputs all update together on the rising clock edge.
module alu_modul #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  alu_modul_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SLT  = 6'b101010;

  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic             ovf_add;
  logic             ovf_sub;

  logic [WIDTH-1:0] result_next;
  logic             carry_next;
  logic             ovf_next;
  logic             zero_next;

  logic [WIDTH-1:0] result_reg;
  logic             carry_reg;
  logic             ovf_reg;
  logic             zero_reg;

  // sub and slt share the same adder path, computed as Rs + ~Rt + 1.
  assign sum_add = {1'b0, bus.Rs} + {1'b0, bus.Rt};
  assign sum_sub = {1'b0, bus.Rs} + {1'b0, ~bus.Rt} + {{WIDTH{1'b0}}, 1'b1};

  assign ovf_add = (bus.Rs[MSB] == bus.Rt[MSB]) && (sum_add[MSB] != bus.Rs[MSB]);
  assign ovf_sub = (bus.Rs[MSB] != bus.Rt[MSB]) && (sum_sub[MSB] != bus.Rs[MSB]);

  always_comb begin
    result_next = '0;
    carry_next  = 1'b0;
    ovf_next    = 1'b0;
    case (bus.Funct)
      F_ADD: begin
        result_next = sum_add[MSB:0];
        carry_next  = sum_add[WIDTH];
        ovf_next    = ovf_add;
      end
      F_SUB: begin
        result_next = sum_sub[MSB:0];
        carry_next  = sum_sub[WIDTH];
        ovf_next    = ovf_sub;
      end
      F_AND:  result_next = bus.Rs & bus.Rt;
      F_OR:   result_next = bus.Rs | bus.Rt;
      F_SLL:  result_next = bus.Rs << bus.Shamt;
      F_SRL:  result_next = bus.Rs >> bus.Shamt;
      F_SRA:  result_next = $unsigned($signed(bus.Rs) >>> bus.Shamt);
      F_SLLV: result_next = bus.Rs << bus.Rt[4:0];
      // The xor with the overflow bit keeps the sign test correct when the difference wraps.
      F_SLT:  result_next = {{(WIDTH-1){1'b0}}, sum_sub[MSB] ^ ovf_sub};
      default: result_next = '0;
    endcase
    zero_next = (result_next == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg <= '0;
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      result_reg <= result_next;
      carry_reg  <= carry_next;
      ovf_reg    <= ovf_next;
      zero_reg   <= zero_next;
    end
  end

  assign bus.Result   = result_reg;
  assign bus.carryOut = carry_reg;
  assign bus.overFlow = ovf_reg;
  assign bus.Zero     = zero_reg;
endmodule

// File: tb/tb_alu_modul.sv
// Testbench for alu_modul: directed cases plus random operations.
// Every result is compared against an arithmetic model of the ALU's behaviour.
module tb_alu_modul;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_modul_if #(.WIDTH(32)) bus ();

  alu_modul #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Packed as {Result, carryOut, Zero, overFlow}.
  function automatic logic [34:0] model(input logic [5:0] f, input logic [4:0] sh,
                                        input logic [31:0] a, input logic [31:0] b);
    longint    ua, ub, sa, sb, d;
    logic [31:0] r;
    logic      c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0;
    c = 1'b0;
    v = 1'b0;
    case (f)
      6'b100000: begin
        d = ua + ub;
        r = d[31:0];
        c = (d >= 64'sd4294967296);
        d = sa + sb;
        v = (d != longint'($signed(d[31:0])));
      end
      6'b100010: begin
        d = ua - ub;
        r = d[31:0];
        c = (ua >= ub);
        d = sa - sb;
        v = (d != longint'($signed(d[31:0])));
      end
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      6'b000000: r = a << sh;
      6'b000010: r = a >> sh;
      6'b000011: begin
        d = sa >>> sh;
        r = d[31:0];
      end
      6'b000100: r = a << b[4:0];
      6'b101010: r = (sa < sb) ? 32'd1 : 32'd0;
      default:   r = 32'd0;
    endcase
    return {r, c, (r == 32'd0), v};
  endfunction

  task automatic check(input string tag, input logic [34:0] exp);
    logic [34:0] got;
    got = {bus.Result, bus.carryOut, bus.Zero, bus.overFlow};
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got res=%h c=%b z=%b v=%b, expected res=%h c=%b z=%b v=%b",
             tag, got[34:3], got[2], got[1], got[0], exp[34:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] f, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b);
    bus.Funct = f;
    bus.Shamt = sh;
    bus.Rs    = a;
    bus.Rt    = b;
    @(posedge clk);
    #1;
    check(tag, model(f, sh, a, b));
    $display("%s f=%b sh=%0d rs=%h rt=%h -> res=%h c=%b z=%b v=%b",
             tag, f, sh, a, b, bus.Result, bus.carryOut, bus.Zero, bus.overFlow);
  endtask

  logic [5:0] ops [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000000,
                          6'b000010, 6'b000011, 6'b000100, 6'b101010};

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.Funct = 6'b100000;
      bus.Shamt = 5'($urandom);
      bus.Rs    = $urandom;
      bus.Rt    = $urandom;
      @(posedge clk);
      #1;
      check("reset", 35'd0);
      $display("reset cycle %0d -> res=%h z=%b", i, bus.Result, bus.Zero);
    end
    rst = 1'b0;
    step("add_3_4",   6'b100000, 5'd0, 32'd3, 32'd4);
    step("add_carry", 6'b100000, 5'd0, 32'hFFFFFFFF, 32'h0000000F);
    step("add_ovf",   6'b100000, 5'd0, 32'h7FFFFFFF, 32'd1);
    step("sub_neg",   6'b100010, 5'd0, 32'd11068, 32'd15786);
    step("sub_ovf",   6'b100010, 5'd0, 32'h80000000, 32'd1);
    step("sub_eq",    6'b100010, 5'd0, 32'd77, 32'd77);
    step("and",       6'b100100, 5'd0, 32'd110234, 32'd104567);
    step("or",        6'b100101, 5'd0, 32'd11024, 32'd10234);
    step("sra_min",   6'b000011, 5'd5, 32'h80000000, 32'd0);
    step("sra_m6",    6'b000011, 5'd4, 32'hFFFFFFFA, 32'd0);
    step("srl",       6'b000010, 5'd1, 32'd1104345, 32'd0);
    step("sll",       6'b000000, 5'd2, 32'd14, 32'hFFFFFFFF);
    step("sll_0",     6'b000000, 5'd0, 32'hDEADBEEF, 32'd0);
    step("sllv",      6'b000100, 5'd9, 32'd24, 32'd10456);
    step("slt_m4_4",  6'b101010, 5'd0, 32'hFFFFFFFC, 32'd4);
    step("slt_5",     6'b101010, 5'd0, 32'd5, 32'h11111111);
    step("slt_zero",  6'b101010, 5'd0, 32'h1000, 32'h100);
    step("slt_min",   6'b101010, 5'd0, 32'h80000000, 32'd1);
    step("slt_wrap",  6'b101010, 5'd0, 32'h7FFFFFFF, 32'h80000000);
    step("undef",     6'b111111, 5'd3, 32'h12345678, 32'h9ABCDEF0);

    // A reset in the middle of a stream discards the in-flight operation.
    bus.Funct = 6'b100000;
    bus.Rs    = 32'hFFFFFFFF;
    bus.Rt    = 32'hFFFFFFFF;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset", 35'd0);
    $display("mid_reset -> res=%h c=%b z=%b v=%b", bus.Result, bus.carryOut, bus.Zero, bus.overFlow);
    rst = 1'b0;

    for (int i = 0; i < 300; i++) begin
      logic [5:0]  f;
      logic [31:0] a, b;
      f = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
      a = $urandom;
      b = $urandom;
      // Bias some operands toward the sign and overflow boundaries.
      if ($urandom_range(0, 3) == 0) a = {a[31], {31{~a[31]}}};
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 2);
      step("rand", f, 5'($urandom), a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
